sreg_serializer: RTL and testbench

Parallel-to-serial stage that sits directly upstream of the serial-to-byte marshaller and produces its serial bit stream. Bytes enter through a valid/ready handshake into a small FIFO and are shifted out LSB-first, one bit per clock, in free-running 8-cycle frames. When no byte is queued at a frame boundary, an idle byte is sent instead, so the bit stream never stalls and the downstream shift register keeps a fixed 8-cycle cadence.

---
 rtl/sreg_serializer.sv | 144 ++++++++++++++
 tb/tb_sreg_serializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sreg_serializer.sv
// Parallel-to-serial stage: bytes queue in a small FIFO and leave LSB-first in
// free-running 8-cycle frames; an idle byte fills any frame with no queued data.
module sreg_serializer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        serial_out,
    output logic                        frame_start,
    output logic                        busy,
    output logic                        underrun,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    // FIFO storage and pointers
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_count;

    // Shifter state and registered outputs
    logic [7:0]    r_sh;
    logic [2:0]    r_bcnt;
    logic          r_last_busy;
    logic          r_serial;
    logic          r_frame_start;
    logic          r_busy;
    logic          r_underrun;

    // Next-state values
    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_rptr_nxt;
    logic [LW-1:0] w_count_nxt;
    logic [7:0]    w_sh_nxt;
    logic          w_last_busy_nxt;
    logic          w_serial_nxt;
    logic          w_frame_start_nxt;
    logic          w_busy_nxt;
    logic          w_underrun_nxt;

    logic          w_ready;
    logic          w_push;
    logic          w_load;
    logic          w_pop;
    logic [7:0]    w_head;

    // Ready depends only on the registered count, never on in_valid
    assign w_ready = (r_count < LW'(DEPTH));
    assign w_push  = in_valid && w_ready;
    assign w_load  = (r_bcnt == 3'd0);
    assign w_pop   = w_load && (r_count != '0);
    assign w_head  = r_mem[r_rptr];

    always_comb begin
        w_wptr_nxt        = r_wptr;
        w_rptr_nxt        = r_rptr;
        w_count_nxt       = r_count;
        w_sh_nxt          = r_sh;
        w_last_busy_nxt   = r_last_busy;
        w_serial_nxt      = r_serial;
        w_frame_start_nxt = 1'b0;
        w_busy_nxt        = r_busy;
        w_underrun_nxt    = 1'b0;

        if (w_push) begin
            w_wptr_nxt = r_wptr + AW'(1);
        end
        if (w_pop) begin
            w_rptr_nxt = r_rptr + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + LW'(1);
            2'b01:   w_count_nxt = r_count - LW'(1);
            default: w_count_nxt = r_count;
        endcase

        // Load edge picks the next frame's byte; other edges shift out sh[bcnt]
        if (w_load) begin
            w_frame_start_nxt = 1'b1;
            if (w_pop) begin
                w_sh_nxt        = w_head;
                w_serial_nxt    = w_head[0];
                w_busy_nxt      = 1'b1;
                w_last_busy_nxt = 1'b1;
            end else begin
                w_sh_nxt        = IDLE_BYTE;
                w_serial_nxt    = IDLE_BYTE[0];
                w_busy_nxt      = 1'b0;
                w_underrun_nxt  = r_last_busy;
                w_last_busy_nxt = 1'b0;
            end
        end else begin
            w_serial_nxt = r_sh[r_bcnt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_sh          <= IDLE_BYTE;
            r_bcnt        <= 3'd0;
            r_last_busy   <= 1'b0;
            r_serial      <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_wptr        <= w_wptr_nxt;
            r_rptr        <= w_rptr_nxt;
            r_count       <= w_count_nxt;
            r_sh          <= w_sh_nxt;
            r_bcnt        <= r_bcnt + 3'd1;
            r_last_busy   <= w_last_busy_nxt;
            r_serial      <= w_serial_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_busy        <= w_busy_nxt;
            r_underrun    <= w_underrun_nxt;
        end
    end

    // Storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    assign in_ready    = w_ready;
    assign serial_out  = r_serial;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign underrun    = r_underrun;
    assign level       = r_count;

endmodule

// File: tb/tb_sreg_serializer.sv
// Directed bench for sreg_serializer: reset, single byte, fill, stream,
// load-edge write and mid-frame reset, all with hand-computed expectations.
module tb_sreg_serializer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic [7:0]    in_data  = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          serial_out;
    logic          frame_start;
    logic          busy;
    logic          underrun;
    logic [LW-1:0] level;

    int n_checks = 0;
    int n_err    = 0;

    // Per-frame plan: write valid/data before each edge, expected level after it
    bit         fv [8];
    logic [7:0] fd [8];
    int         fl [8];

    sreg_serializer #(.DEPTH(DEPTH), .IDLE_BYTE(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .serial_out  (serial_out),
        .frame_start (frame_start),
        .busy        (busy),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic plan(input int lvl);
        for (int i = 0; i < 8; i++) begin
            fv[i] = 1'b0;
            fd[i] = 8'h00;
            fl[i] = lvl;
        end
    endtask

    // Runs nbits edges from a load edge, checking every output after each edge
    task automatic frame(input string name, input logic [7:0] eb, input logic ebusy,
                         input logic eund, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            in_valid = fv[k];
            in_data  = fd[k];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("%s.bit%0d", name, k), 32'(serial_out), 32'(eb[k]));
            chk($sformatf("%s.fs%0d", name, k), 32'(frame_start), 32'(k == 0));
            chk($sformatf("%s.busy%0d", name, k), 32'(busy), 32'(ebusy));
            chk($sformatf("%s.und%0d", name, k), 32'(underrun), 32'((k == 0) ? eund : 1'b0));
            if (fl[k] >= 0) begin
                chk($sformatf("%s.lvl%0d", name, k), 32'(level), 32'(fl[k]));
                chk($sformatf("%s.rdy%0d", name, k), 32'(in_ready), 32'(fl[k] < DEPTH));
            end
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, ".ser"}, 32'(serial_out), 32'd0);
        chk({name, ".fs"}, 32'(frame_start), 32'd0);
        chk({name, ".busy"}, 32'(busy), 32'd0);
        chk({name, ".und"}, 32'(underrun), 32'd0);
        chk({name, ".lvl"}, 32'(level), 32'd0);
        chk({name, ".rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Power-on reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame idle without underrun; 0xA5 written mid-frame
        plan(0);
        fv[3] = 1'b1; fd[3] = 8'hA5;
        fl[3] = 1; fl[4] = 1; fl[5] = 1; fl[6] = 1; fl[7] = 1;
        frame("f0_idle", 8'h00, 1'b0, 1'b0, 8);
        plan(0);
        frame("f1_a5", 8'hA5, 1'b1, 1'b0, 8);
        plan(0);
        frame("f2_und", 8'h00, 1'b0, 1'b1, 8);

        // Fill: four accepted, 0x55 held off until the pop frees a slot
        plan(4);
        fl[0] = 0; fl[1] = 1; fl[2] = 2; fl[3] = 3;
        fv[1] = 1'b1; fd[1] = 8'h11;
        fv[2] = 1'b1; fd[2] = 8'h22;
        fv[3] = 1'b1; fd[3] = 8'h33;
        fv[4] = 1'b1; fd[4] = 8'h44;
        for (int i = 5; i < 8; i++) begin
            fv[i] = 1'b1; fd[i] = 8'h55;
        end
        frame("f3_fill", 8'h00, 1'b0, 1'b0, 8);
        plan(4);
        fl[0] = 3;
        fv[0] = 1'b1; fd[0] = 8'h55;
        fv[1] = 1'b1; fd[1] = 8'h55;
        frame("f4_11", 8'h11, 1'b1, 1'b0, 8);
        plan(3);
        frame("f5_22", 8'h22, 1'b1, 1'b0, 8);
        plan(2);
        frame("f6_33", 8'h33, 1'b1, 1'b0, 8);
        plan(1);
        frame("f7_44", 8'h44, 1'b1, 1'b0, 8);

        // Continuous stream queued while 0x55 goes out
        plan(4);
        fl[0] = 0; fl[1] = 1; fl[2] = 2; fl[3] = 3;
        fv[1] = 1'b1; fd[1] = 8'h01;
        fv[2] = 1'b1; fd[2] = 8'h80;
        fv[3] = 1'b1; fd[3] = 8'hFF;
        fv[4] = 1'b1; fd[4] = 8'h00;
        frame("f8_55", 8'h55, 1'b1, 1'b0, 8);
        plan(3);
        frame("f9_01", 8'h01, 1'b1, 1'b0, 8);
        plan(2);
        frame("f10_80", 8'h80, 1'b1, 1'b0, 8);
        plan(1);
        frame("f11_ff", 8'hFF, 1'b1, 1'b0, 8);
        plan(0);
        frame("f12_00", 8'h00, 1'b1, 1'b0, 8);
        plan(0);
        frame("f13_und", 8'h00, 1'b0, 1'b1, 8);

        // Write on a load edge into an empty FIFO: no bypass
        plan(1);
        fv[0] = 1'b1; fd[0] = 8'h3C;
        frame("f14_idle", 8'h00, 1'b0, 1'b0, 8);
        plan(0);
        frame("f15_3c", 8'h3C, 1'b1, 1'b0, 8);
        plan(0);
        frame("f16_und", 8'h00, 1'b0, 1'b1, 8);

        // Queue three bytes, then reset three bits into the first data frame
        plan(3);
        fl[0] = 0; fl[1] = 1; fl[2] = 2;
        fv[1] = 1'b1; fd[1] = 8'hAA;
        fv[2] = 1'b1; fd[2] = 8'hBB;
        fv[3] = 1'b1; fd[3] = 8'hCC;
        frame("f17_q", 8'h00, 1'b0, 1'b0, 8);
        plan(2);
        frame("f18_aa", 8'hAA, 1'b1, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk);
        #1;
        chk_reset("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Only idle frames afterwards; queued bytes are gone
        for (int f = 0; f < 3; f++) begin
            plan(0);
            frame($sformatf("post%0d", f), 8'h00, 1'b0, 1'b0, 8);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
